// File: rtl/jump_request_gen.sv
// jump_request_gen
// Initiator side of the menu jump handshake. A synchronised, debounced
// push-button press or an auto-demo timer tick becomes a single-cycle JPulse
// toward the sprite. A pulse is only fired while the sprite reports idle.
// One request can be held back while a jump is already in flight. The block
// watches the sprite's jump/done_move response, flags a sprite that never
// acknowledges, and counts completed jumps.

module jump_request_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int ACK_TIMEOUT     = 1024,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             auto_en,
    input  logic             jump,
    input  logic             done_move,
    output logic             JPulse,
    output logic             busy,
    output logic             pending,
    output logic             ack_timeout,
    output logic [CNT_W-1:0] jump_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AU_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AU_W-1:0] AU_LAST = AU_W'(AUTO_PERIOD - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FIRE      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   synced_s;
    logic [DB_W-1:0]        db_cnt_r;
    logic                   stable_r;
    logic                   btn_req_r;
    logic [AU_W-1:0]        auto_cnt_r;
    logic                   auto_run_s;
    logic                   auto_req_s;
    logic                   req_s;
    state_t                 state_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic                   jpulse_r;
    logic                   busy_r;
    logic                   pending_r;
    logic                   ack_timeout_r;
    logic [CNT_W-1:0]       jump_count_r;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Metastability synchroniser: the only logic that samples btn_raw.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Debouncer: the level flips only after the synced input has disagreed for
    // DEBOUNCE_CYCLES in a row. Only a rising flip raises a one-cycle request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt_r  <= {DB_W{1'b0}};
            stable_r  <= 1'b0;
            btn_req_r <= 1'b0;
        end else begin
            btn_req_r <= 1'b0;
            if (synced_s != stable_r) begin
                if (db_cnt_r == DB_LAST) begin
                    stable_r  <= synced_s;
                    db_cnt_r  <= {DB_W{1'b0}};
                    btn_req_r <= synced_s;
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end else begin
                db_cnt_r <= {DB_W{1'b0}};
            end
        end
    end

    // The auto-demo timer only runs while the handshake is completely at rest,
    // so it restarts from zero after every jump.
    assign auto_run_s = auto_en && (state_r == ST_IDLE) && !pending_r;
    assign auto_req_s = auto_run_s && (auto_cnt_r == AU_LAST);
    assign req_s      = btn_req_r | auto_req_s;

    // Auto-demo period counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_cnt_r <= {AU_W{1'b0}};
        end else if (!auto_run_s || (auto_cnt_r == AU_LAST)) begin
            auto_cnt_r <= {AU_W{1'b0}};
        end else begin
            auto_cnt_r <= auto_cnt_r + AU_W'(1);
        end
    end

    // Handshake FSM with registered JPulse/busy/pending/ack_timeout/count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            to_cnt_r      <= {TO_W{1'b0}};
            jpulse_r      <= 1'b0;
            busy_r        <= 1'b0;
            pending_r     <= 1'b0;
            ack_timeout_r <= 1'b0;
            jump_count_r  <= {CNT_W{1'b0}};
        end else begin
            jpulse_r <= 1'b0;
            // A request arriving mid-handshake is queued one deep. Further
            // requests are absorbed while the queue is already full.
            if ((state_r != ST_IDLE) && req_s) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if ((req_s || pending_r) && done_move) begin
                        state_r   <= ST_FIRE;
                        jpulse_r  <= 1'b1;
                        busy_r    <= 1'b1;
                        pending_r <= 1'b0;
                    end else if (req_s) begin
                        pending_r <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    state_r  <= ST_WAIT_ACK;
                    to_cnt_r <= {TO_W{1'b0}};
                end
                ST_WAIT_ACK: begin
                    if (jump) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r       <= ST_IDLE;
                        busy_r        <= 1'b0;
                        ack_timeout_r <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_move && !jump) begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        jump_count_r <= jump_count_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign JPulse      = jpulse_r;
    assign busy        = busy_r;
    assign pending     = pending_r;
    assign ack_timeout = ack_timeout_r;
    assign jump_count  = jump_count_r;

endmodule
